ft601_mcfifo_rd_buf: RTL and testbench

Single-clock receive buffer for the FT601 multi-channel FIFO interface, the host-to-FPGA direction. It runs in the FT601 clock domain and accepts packets from the bus-side channel engine. It advertises readiness only when a full maximum-size packet is guaranteed to fit, tags each packet's final word, and drains to user logic through a registered read port.

---
 rtl/ft601_pkg.sv | 33 +++
 rtl/ft601_sdp_ram.sv | 51 +++++
 rtl/ft601_mcfifo_rd_buf.sv | 191 +++++++++++++++++++
 tb/tb_ft601_mcfifo_rd_buf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ft601_pkg.sv
// ---------------------------------------------------------------------------
// ft601_pkg
//   Shared definitions for the FT601 multi-channel FIFO receive path.
//   - ft_state_e       : receive-buffer control states (IDLE, READY, XFER)
//   - FT_WORD_W        : bus word width, {be[3:0], data[31:0]}
//   - FT_BE_W          : byte-enable width
//   - FT_ENTRY_W       : stored entry width, {last, be, data}
//   - ft_pkt_words()   : packet size in bytes -> words, clamped to a maximum
// ---------------------------------------------------------------------------
package ft601_pkg;

  localparam int unsigned FT_WORD_W  = 36;
  localparam int unsigned FT_BE_W    = 4;
  localparam int unsigned FT_ENTRY_W = FT_WORD_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    XFER  = 2'd2
  } ft_state_e;

  // Converts a byte count into 32-bit words and clamps it to the largest
  // packet the buffer was built for.
  function automatic logic [31:0] ft_pkt_words(input logic [31:0] size_bytes,
                                               input int unsigned max_bytes);
    logic [31:0] req_words;
    logic [31:0] max_words;
    req_words = size_bytes >> 2;
    max_words = 32'(max_bytes / 4);
    return (req_words > max_words) ? max_words : req_words;
  endfunction

endpackage : ft601_pkg

// File: rtl/ft601_sdp_ram.sv
// ---------------------------------------------------------------------------
// ft601_sdp_ram
//   Single-clock simple dual-port RAM with a registered read port. The
//   storage array has no reset so it maps onto block RAM; only the read
//   output register is reset so the popped-data outputs start at zero.
//
//   Ports:
//     clk        in   clock
//     rst_n_i    in   asynchronous active-low reset (read register only)
//     wr_en_i    in   write strobe
//     wr_addr_i  in   write address
//     wr_data_i  in   write data
//     rd_en_i    in   read strobe; rd_data_o updates on the next edge
//     rd_addr_i  in   read address
//     rd_data_o  out  registered read data
// ---------------------------------------------------------------------------
module ft601_sdp_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 37,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : ft601_sdp_ram

// File: rtl/ft601_mcfifo_rd_buf.sv
// ---------------------------------------------------------------------------
// ft601_mcfifo_rd_buf
//   Host-to-FPGA receive buffer for the FT601 multi-channel FIFO interface.
//   The bus side is only offered a transfer (xfer_req) once a whole
//   maximum-size packet is guaranteed to fit, so accepted words are never
//   refused. The final word of each packet is tagged and returned as
//   rd_last on the registered read port.
//
//   Ports:
//     clk              in   FT601 clock
//     reset_n          in   asynchronous active-low reset
//     max_packet_size  in   packet size in bytes (static during transfers)
//     xfer_req         out  space for one full packet reserved
//     xfer_data        in   {be[3:0], data[31:0]}
//     xfer_valid       in   xfer_data valid this cycle
//     xfer_done        in   host ended the transfer
//     xfer_overflow    out  sticky: a word was dropped / packet cut short
//     rd_en            in   pop request
//     rd_data          out  popped word
//     rd_last          out  popped word ends its packet
//     rd_valid         out  one-cycle pulse per pop
//     rd_empty         out  no stored words
//     rd_count         out  stored word count
// ---------------------------------------------------------------------------
module ft601_mcfifo_rd_buf
  import ft601_pkg::*;
#(
  parameter int unsigned CAPACITY        = 128,
  parameter int unsigned MAX_PACKET_SIZE = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                max_packet_size,
  output logic                       xfer_req,
  input  logic [FT_WORD_W-1:0]       xfer_data,
  input  logic                       xfer_valid,
  input  logic                       xfer_done,
  output logic                       xfer_overflow,
  input  logic                       rd_en,
  output logic [FT_WORD_W-1:0]       rd_data,
  output logic                       rd_last,
  output logic                       rd_valid,
  output logic                       rd_empty,
  output logic [$clog2(CAPACITY):0]  rd_count
);

  localparam int unsigned AW = $clog2(CAPACITY);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] CAP_WORDS = 32'(CAPACITY);

  ft_state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic          xfer_req_q, xfer_req_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q;

  logic [31:0]   pkt_words;
  logic          pkt_ok;
  logic [31:0]   free_words;
  logic          wr_en;
  logic          wr_last;
  logic          rd_fire;
  logic [FT_ENTRY_W-1:0] ram_rdata;

  assign pkt_words  = ft_pkt_words(max_packet_size, MAX_PACKET_SIZE);
  // A zero or oversized packet could never be fully reserved, so the bus
  // side is simply never invited to transfer.
  assign pkt_ok     = (pkt_words != 32'd0) && (pkt_words <= CAP_WORDS);
  assign free_words = CAP_WORDS - 32'(count_q);
  assign rd_fire    = rd_en && (count_q != '0);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_last = 1'b0;

    case (state_q)
      IDLE: begin
        // No space has been reserved, so anything arriving now is lost.
        if (xfer_valid) begin
          ovf_d = 1'b1;
        end
        if (pkt_ok && (free_words >= pkt_words)) begin
          state_d = READY;
        end
      end

      READY, XFER: begin
        if (xfer_valid) begin
          wr_en   = 1'b1;
          wr_last = ((32'(wcnt_q) + 32'd1) == pkt_words) || xfer_done;
          if (wr_last) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else begin
            state_d = XFER;
            wcnt_d  = wcnt_q + 1'b1;
          end
        end else if (xfer_done) begin
          // A done without a word: in READY nothing was written; in XFER the
          // previous word is already stored without its last tag, so the
          // packet boundary is lost and that is flagged.
          state_d = IDLE;
          wcnt_d  = '0;
          if (state_q == XFER) begin
            ovf_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  assign xfer_req_d = (state_d != IDLE);

  // -------------------------------------------------------------------------
  // Occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      xfer_req_q <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      count_q    <= count_d;
      xfer_req_q <= xfer_req_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_fire;
      if (wr_en) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (rd_fire) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage: {last, be, data}
  // -------------------------------------------------------------------------
  ft601_sdp_ram #(
    .DEPTH (CAPACITY),
    .WIDTH (FT_ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n_i   (reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wptr_q),
    .wr_data_i ({wr_last, xfer_data}),
    .rd_en_i   (rd_fire),
    .rd_addr_i (rptr_q),
    .rd_data_o (ram_rdata)
  );

  assign xfer_req      = xfer_req_q;
  assign xfer_overflow = ovf_q;
  assign rd_data       = ram_rdata[FT_WORD_W-1:0];
  assign rd_last       = ram_rdata[FT_ENTRY_W-1];
  assign rd_valid      = rd_valid_q;
  assign rd_empty      = (count_q == '0);
  assign rd_count      = count_q;

endmodule : ft601_mcfifo_rd_buf

// File: tb/tb_ft601_mcfifo_rd_buf.sv
module tb_ft601_mcfifo_rd_buf;

  logic        clk;
  logic        reset_n;
  logic [31:0] max_packet_size;
  logic        xfer_req;
  logic [35:0] xfer_data;
  logic        xfer_valid;
  logic        xfer_done;
  logic        xfer_overflow;
  logic        rd_en;
  logic [35:0] rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_empty;
  logic [7:0]  rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  ft601_mcfifo_rd_buf #(
    .CAPACITY        (128),
    .MAX_PACKET_SIZE (1024)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .max_packet_size (max_packet_size),
    .xfer_req        (xfer_req),
    .xfer_data       (xfer_data),
    .xfer_valid      (xfer_valid),
    .xfer_done       (xfer_done),
    .xfer_overflow   (xfer_overflow),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_last         (rd_last),
    .rd_valid        (rd_valid),
    .rd_empty        (rd_empty),
    .rd_count        (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    for (int k = 0; k < budget && xfer_req !== 1'b1; k++) tick();
    check_eq("xfer_req_wait", {63'd0, xfer_req}, 64'd1);
  endtask

  // Word i (1..n) carries data base+i, be=F; done optionally on the last word.
  task automatic write_pkt(input int base, input int n, input bit done_on_last);
    for (int i = 1; i <= n; i++) begin
      xfer_valid = 1'b1;
      xfer_data  = {4'hF, 32'(base + i)};
      xfer_done  = done_on_last && (i == n);
      tick();
    end
    xfer_valid = 1'b0;
    xfer_done  = 1'b0;
    xfer_data  = '0;
    $display("write packet: base=%0d words=%0d done=%0d count=%0d", base, n, done_on_last, rd_count);
  endtask

  // Back-to-back pops; expects data base+i and last every last_every words.
  task automatic drain(input int base, input int n, input int last_every);
    rd_en = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      check_eq("rd_valid", {63'd0, rd_valid}, 64'd1);
      check_eq("rd_data", {28'd0, rd_data}, {28'd0, 4'hF, 32'(base + i)});
      check_eq("rd_last", {63'd0, rd_last}, {63'd0, ((i % last_every) == 0)});
    end
    rd_en = 1'b0;
    $display("drain: base=%0d words=%0d count=%0d", base, n, rd_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    max_packet_size = 32'd64;
    xfer_data       = '0;
    xfer_valid      = 1'b0;
    xfer_done       = 1'b0;
    rd_en           = 1'b0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_xfer_req", {63'd0, xfer_req}, 64'd0);
    check_eq("rst_overflow", {63'd0, xfer_overflow}, 64'd0);
    check_eq("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("rst_rd_data", {28'd0, rd_data}, 64'd0);
    check_eq("rst_rd_last", {63'd0, rd_last}, 64'd0);
    check_eq("rst_rd_empty", {63'd0, rd_empty}, 64'd1);
    check_eq("rst_rd_count", {56'd0, rd_count}, 64'd0);
    $display("reset: values checked");

    reset_n = 1'b1;
    repeat (10) tick();
    check_eq("idle_xfer_req", {63'd0, xfer_req}, 64'd1);
    check_eq("idle_rd_empty", {63'd0, rd_empty}, 64'd1);
    check_eq("idle_rd_count", {56'd0, rd_count}, 64'd0);

    // One full packet
    write_pkt(0, 16, 1'b0);
    check_eq("pkt1_req_drop", {63'd0, xfer_req}, 64'd0);
    check_eq("pkt1_count", {56'd0, rd_count}, 64'd16);
    check_eq("pkt1_not_empty", {63'd0, rd_empty}, 64'd0);
    check_eq("pkt1_rd_valid_idle", {63'd0, rd_valid}, 64'd0);
    drain(0, 16, 16);
    check_eq("pkt1_empty", {63'd0, rd_empty}, 64'd1);
    tick();
    check_eq("rd_valid_pulse", {63'd0, rd_valid}, 64'd0);

    // Fill the buffer with 8 packets
    for (int p = 0; p < 8; p++) begin
      wait_req(4);
      write_pkt(100 + 16 * p, 16, 1'b0);
    end
    check_eq("full_count", {56'd0, rd_count}, 64'd128);
    repeat (3) tick();
    check_eq("full_req_low", {63'd0, xfer_req}, 64'd0);

    // Word offered while full is dropped
    xfer_valid = 1'b1;
    xfer_data  = {4'hF, 32'hDEAD};
    tick();
    xfer_valid = 1'b0;
    xfer_data  = '0;
    tick();
    check_eq("ovf_count", {56'd0, rd_count}, 64'd128);
    check_eq("ovf_flag", {63'd0, xfer_overflow}, 64'd1);
    $display("overflow word offered while full");

    drain(100, 16, 16);
    check_eq("after16_count", {56'd0, rd_count}, 64'd112);
    wait_req(2);
    drain(116, 112, 16);
    check_eq("drained_empty", {63'd0, rd_empty}, 64'd1);

    // Short packet ended by done on its last word
    wait_req(4);
    write_pkt(200, 8, 1'b1);
    check_eq("short_count", {56'd0, rd_count}, 64'd8);
    check_eq("short_req_drop", {63'd0, xfer_req}, 64'd0);
    drain(200, 8, 8);
    check_eq("ovf_sticky", {63'd0, xfer_overflow}, 64'd1);

    // Reset in the middle of a packet, at word 5
    wait_req(4);
    write_pkt(300, 4, 1'b0);
    xfer_valid = 1'b1;
    xfer_data  = {4'hF, 32'd305};
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_xfer_req", {63'd0, xfer_req}, 64'd0);
    check_eq("mid_rst_overflow", {63'd0, xfer_overflow}, 64'd0);
    check_eq("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("mid_rst_rd_data", {28'd0, rd_data}, 64'd0);
    check_eq("mid_rst_rd_last", {63'd0, rd_last}, 64'd0);
    check_eq("mid_rst_rd_empty", {63'd0, rd_empty}, 64'd1);
    check_eq("mid_rst_rd_count", {56'd0, rd_count}, 64'd0);
    $display("reset asserted mid-packet");
    xfer_valid = 1'b0;
    xfer_data  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_empty", {63'd0, rd_empty}, 64'd1);
    wait_req(4);
    write_pkt(400, 16, 1'b0);
    check_eq("post_rst_count", {56'd0, rd_count}, 64'd16);
    drain(400, 16, 16);
    check_eq("post_rst_drained", {63'd0, rd_empty}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ft601_mcfifo_rd_buf
